// File: rtl/bvb_bank_scheduler_if.sv
// Bus bundle between the bank scheduler, the per-channel id FIFOs / SpMV channels,
// and the vector RAM address port.
interface bvb_bank_scheduler_if #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned BANK_BITS   = 3,
  parameter int unsigned ADDR_BITS   = 10
);
  logic                             start;
  logic [ADDR_BITS-1:0]             image_base;
  logic [CHANNEL_NUM*BANK_BITS-1:0] head_bank;
  logic [CHANNEL_NUM-1:0]           head_valid;
  logic [CHANNEL_NUM-1:0]           chan_done;
  logic [ADDR_BITS-1:0]             ram_addr;
  logic [BANK_BITS-1:0]             bank_sel;
  logic                             bank_valid;
  logic                             busy;
  logic                             image_done;

  modport master (
    output start, image_base, head_bank, head_valid, chan_done,
    input  ram_addr, bank_sel, bank_valid, busy, image_done
  );

  modport slave (
    input  start, image_base, head_bank, head_valid, chan_done,
    output ram_addr, bank_sel, bank_valid, busy, image_done
  );
endinterface

// File: rtl/bvb_bank_scheduler.sv
// Demand-driven bank sequencer: presents only banks some channel head is waiting on,
// round-robin among rivals with a dwell cap, and sequences one image per start pulse.
module bvb_bank_scheduler #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned BANK_BITS   = 3,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned MAX_DWELL   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bvb_bank_scheduler_if.slave   bus
);

  localparam int unsigned NumBanks = 1 << BANK_BITS;
  localparam int unsigned DwellW   = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
  localparam logic [DwellW-1:0] DwellCap = DwellW'(MAX_DWELL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
  logic [BANK_BITS-1:0]   bank_sel_q, bank_sel_d;
  logic [BANK_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DwellW-1:0]      dwell_q, dwell_d;
  logic [CHANNEL_NUM-1:0] done_mask_q, done_mask_d;
  logic                   bank_valid_q, bank_valid_d;
  logic                   busy_q, busy_d;
  logic                   image_done_q, image_done_d;

  logic [NumBanks-1:0]    req;
  logic [NumBanks-1:0]    rival;
  logic                   cur_req;
  logic                   grant_found;
  logic [BANK_BITS-1:0]   grant_bank;
  logic [BANK_BITS-1:0]   cand;

  always_comb begin
    req = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (bus.head_valid[c]) req[bus.head_bank[c*BANK_BITS +: BANK_BITS]] = 1'b1;
    end
  end

  // The presented bank is excluded from the rival set; rr_ptr already points past it,
  // so it would be scanned last anyway.
  always_comb begin
    rival   = req;
    cur_req = bank_valid_q & req[bank_sel_q];
    if (bank_valid_q) rival[bank_sel_q] = 1'b0;
  end

  always_comb begin
    grant_found = 1'b0;
    grant_bank  = rr_ptr_q;
    cand        = '0;
    for (int i = 0; i < NumBanks; i++) begin
      cand = rr_ptr_q + BANK_BITS'(i);
      if (!grant_found && rival[cand]) begin
        grant_found = 1'b1;
        grant_bank  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    ram_addr_d   = ram_addr_q;
    bank_sel_d   = bank_sel_q;
    rr_ptr_d     = rr_ptr_q;
    dwell_d      = dwell_q;
    done_mask_d  = done_mask_q;
    bank_valid_d = bank_valid_q;
    busy_d       = busy_q;
    image_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          base_d      = bus.image_base;
          done_mask_d = '0;
          busy_d      = 1'b1;
          state_d     = StRun;
        end
      end
      StRun, StDrain: begin
        if (cur_req && (dwell_q < DwellCap)) begin
          dwell_d = dwell_q + DwellW'(1);
        end else if (grant_found) begin
          bank_sel_d   = grant_bank;
          ram_addr_d   = base_q + ADDR_BITS'(grant_bank);
          rr_ptr_d     = grant_bank + BANK_BITS'(1);
          dwell_d      = '0;
          bank_valid_d = 1'b1;
        end else if (cur_req) begin
          // Cap reached with no rival: keep the bank, restart the dwell window.
          dwell_d = '0;
        end else begin
          bank_valid_d = 1'b0;
          dwell_d      = '0;
        end

        if (state_q == StRun) begin
          done_mask_d = done_mask_q | bus.chan_done;
          if (&done_mask_d) state_d = StDrain;
        end else if (req == '0) begin
          state_d      = StDone;
          image_done_d = 1'b1;
          busy_d       = 1'b0;
          bank_valid_d = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      ram_addr_q   <= '0;
      bank_sel_q   <= '0;
      rr_ptr_q     <= '0;
      dwell_q      <= '0;
      done_mask_q  <= '0;
      bank_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      image_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      ram_addr_q   <= ram_addr_d;
      bank_sel_q   <= bank_sel_d;
      rr_ptr_q     <= rr_ptr_d;
      dwell_q      <= dwell_d;
      done_mask_q  <= done_mask_d;
      bank_valid_q <= bank_valid_d;
      busy_q       <= busy_d;
      image_done_q <= image_done_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.bank_sel   = bank_sel_q;
  assign bus.bank_valid = bank_valid_q;
  assign bus.busy       = busy_q;
  assign bus.image_done = image_done_q;

endmodule

// File: tb/tb_bvb_bank_scheduler.sv
// Directed bench for bvb_bank_scheduler with MAX_DWELL=4; expected values are hand-derived.
module tb_bvb_bank_scheduler;
  localparam int unsigned CN = 4;
  localparam int unsigned BB = 3;
  localparam int unsigned AB = 10;
  localparam int unsigned MD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bvb_bank_scheduler_if #(.CHANNEL_NUM(CN), .BANK_BITS(BB), .ADDR_BITS(AB)) bus ();

  bvb_bank_scheduler #(
    .CHANNEL_NUM(CN),
    .BANK_BITS  (BB),
    .ADDR_BITS  (AB),
    .MAX_DWELL  (MD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int done_pulses = 0;

  always @(negedge clk) if (bus.image_done === 1'b1) done_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic head(input int c, input int b, input bit v);
    bus.head_bank[c*BB +: BB] = BB'(b);
    bus.head_valid[c]         = v;
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.image_base = '0;
    bus.head_bank  = '0;
    bus.head_valid = '0;
    bus.chan_done  = '0;
    tick();
    tick();
    check("rst_addr", 32'(bus.ram_addr), 32'h0);
    check("rst_sel", 32'(bus.bank_sel), 32'h0);
    check("rst_valid", 32'(bus.bank_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.image_done), 32'h0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 32'h0);

    // Basic
    bus.start      = 1'b1;
    bus.image_base = 10'h040;
    tick();
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 32'h1);
    check("start_valid", 32'(bus.bank_valid), 32'h0);
    head(0, 5, 1'b1);
    tick();
    check("basic_sel", 32'(bus.bank_sel), 32'h5);
    check("basic_addr", 32'(bus.ram_addr), 32'h045);
    check("basic_valid", 32'(bus.bank_valid), 32'h1);

    // Skip: move rr_ptr to 2 by granting bank 1, idle a cycle, then banks 1 and 6
    head(0, 1, 1'b1);
    tick();
    check("rr_setup_sel", 32'(bus.bank_sel), 32'h1);
    bus.head_valid = '0;
    tick();
    check("noreq_valid", 32'(bus.bank_valid), 32'h0);
    check("noreq_hold_sel", 32'(bus.bank_sel), 32'h1);
    head(0, 1, 1'b1);
    head(1, 6, 1'b1);
    tick();
    check("skip_first_sel", 32'(bus.bank_sel), 32'h6);
    check("skip_first_valid", 32'(bus.bank_valid), 32'h1);
    check("skip_first_addr", 32'(bus.ram_addr), 32'h046);
    bus.head_valid[1] = 1'b0;
    tick();
    check("skip_second_sel", 32'(bus.bank_sel), 32'h1);
    check("skip_second_addr", 32'(bus.ram_addr), 32'h041);

    // Dwell cap: bank 2 held exactly 4 cycles while bank 3 waits
    bus.head_valid = '0;
    tick();
    head(0, 2, 1'b1);
    head(1, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dwell_hold2", 32'(bus.bank_sel), 32'h2);
    end
    tick();
    check("dwell_switch3", 32'(bus.bank_sel), 32'h3);
    bus.head_valid[1] = 1'b0;
    tick();
    check("solo_grant2", 32'(bus.bank_sel), 32'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("solo_hold_sel", 32'(bus.bank_sel), 32'h2);
      check("solo_hold_valid", 32'(bus.bank_valid), 32'h1);
    end

    // Completion with staggered chan_done and an ignored start while busy
    bus.chan_done = 4'b0001;
    tick();
    bus.chan_done  = 4'b0000;
    bus.start      = 1'b1;
    bus.image_base = 10'h300;
    tick();
    bus.start     = 1'b0;
    bus.chan_done = 4'b0100;
    tick();
    bus.chan_done = 4'b0010;
    tick();
    bus.chan_done = 4'b0000;
    tick();
    check("pre_drain_busy", 32'(bus.busy), 32'h1);
    bus.chan_done = 4'b1000;
    tick();
    bus.chan_done = 4'b0000;
    check("drain_busy", 32'(bus.busy), 32'h1);
    check("drain_no_done", 32'(bus.image_done), 32'h0);
    check("drain_sel", 32'(bus.bank_sel), 32'h2);
    head(0, 4, 1'b1);
    tick();
    check("drain_grant4", 32'(bus.bank_sel), 32'h4);
    check("base_kept_addr", 32'(bus.ram_addr), 32'h044);
    bus.head_valid = '0;
    tick();
    check("done_pulse", 32'(bus.image_done), 32'h1);
    check("done_busy", 32'(bus.busy), 32'h0);
    check("done_valid", 32'(bus.bank_valid), 32'h0);
    bus.start      = 1'b1;
    bus.image_base = 10'h100;
    tick();
    bus.start = 1'b0;
    check("done_pulse_end", 32'(bus.image_done), 32'h0);
    check("start_in_done_ignored", 32'(bus.busy), 32'h0);
    tick();
    check("still_idle", 32'(bus.busy), 32'h0);

    // Address wrap
    bus.start      = 1'b1;
    bus.image_base = 10'h3FE;
    tick();
    bus.start = 1'b0;
    check("wrap_busy", 32'(bus.busy), 32'h1);
    head(0, 3, 1'b1);
    tick();
    check("wrap_sel", 32'(bus.bank_sel), 32'h3);
    check("wrap_addr", 32'(bus.ram_addr), 32'h001);
    check("wrap_valid", 32'(bus.bank_valid), 32'h1);

    // Reset mid-RUN
    rst = 1'b1;
    tick();
    check("mrst_addr", 32'(bus.ram_addr), 32'h0);
    check("mrst_sel", 32'(bus.bank_sel), 32'h0);
    check("mrst_valid", 32'(bus.bank_valid), 32'h0);
    check("mrst_busy", 32'(bus.busy), 32'h0);
    check("mrst_done", 32'(bus.image_done), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(bus.bank_valid), 32'h0);
    check("post_rst_busy", 32'(bus.busy), 32'h0);
    tick();
    check("done_pulse_count", 32'(done_pulses), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bvb_bank_scheduler.md
Name: bvb_bank_scheduler

Overview:
- Demand-driven bank sequencer for the banked vector buffer RAM. It replaces the free-running chunk counter.
- Each cycle it looks at the bank id at the head of every channel's column-id FIFO and selects which RAM chunk (bank) to present. Banks nobody is waiting for are skipped.
- It holds a bank while requests for it remain, subject to a starvation cap. It also sequences images: it latches the image base address and signals completion.
- It sits between the per-channel id FIFOs / SpMV channels and the vector RAM address port.

Parameters:
- CHANNEL_NUM, 4: number of channels.
- BANK_BITS, 3: bank id width; number of banks = 2^BANK_BITS.
- ADDR_BITS, 10: vector RAM address width.
- MAX_DWELL, 8: maximum consecutive cycles on one bank while another bank has a pending request. Must be >= 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse; begins an image. Ignored unless idle.
- image_base, input, ADDR_BITS: RAM address of the image's chunk 0; sampled on an accepted start.
- head_bank, input, CHANNEL_NUM*BANK_BITS: bank id at each channel's FIFO head; channel c occupies bits [c*BANK_BITS +: BANK_BITS].
- head_valid, input, CHANNEL_NUM: channel c's head entry is valid (FIFO not empty).
- chan_done, input, CHANNEL_NUM: pulse or level; channel c has pushed its last id for this image.
- ram_addr, output, ADDR_BITS: vector RAM read address.
- bank_sel, output, BANK_BITS: currently presented bank; compared by channels against head_bank.
- bank_valid, output, 1: bank_sel / ram_addr are meaningful this cycle.
- busy, output, 1: an image is in progress.
- image_done, output, 1: one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; dwell=0; done_mask=0; base register 0.
- Request vector, combinational: req[b] = OR over c of (head_valid[c] & head_bank[c]==b).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE
  - start=1 -> latch image_base, clear done_mask, busy<=1, go RUN.
  - start=0 -> stay IDLE.
- RUN, each cycle:
  - done_mask |= chan_done (sticky).
  - Current bank still requested (req[bank_sel]=1 and bank_valid=1) and dwell < MAX_DWELL-1 -> hold bank_sel, dwell<=dwell+1.
  - Otherwise, if req has any bit set other than the current bank -> grant the first set bank scanning upward from rr_ptr with wrap. Register it into bank_sel, set rr_ptr<=granted+1 (mod 2^BANK_BITS), dwell<=0, bank_valid<=1.
  - If only the current bank is requested and dwell has hit the cap -> keep it and reset dwell to 0; there is no forced switch when no rival exists.
  - req all zero -> bank_valid<=0; bank_sel holds its value.
  - done_mask all ones -> go DRAIN.
- DRAIN: same grant rules as RUN. When req==0 for one full cycle, go DONE.
- DONE: image_done=1 for exactly one cycle; busy<=0; bank_valid<=0; go IDLE.
- ram_addr <= base + zero-extended bank_sel, modulo 2^ADDR_BITS (wraps silently). It is updated in the same register stage as bank_sel.
- Latency: a request appearing at cycle N yields bank_valid/bank_sel at cycle N+1 at the earliest.
- The channel consumes an id when head_bank==bank_sel & bank_valid.
- start while busy: ignored. start in the same cycle as DONE: ignored.
- chan_done arriving in the same cycle as the transition to DRAIN is still captured.
- rst mid-image: return to IDLE immediately next cycle with all outputs 0; no image_done pulse.
- Fairness bound: any requested bank is granted within (2^BANK_BITS - 1)*MAX_DWELL + 1 cycles.

Test Plan:
- Basic: reset, start with image_base=0x040, channel 0 head_bank=5 valid -> cycle+1 bank_sel=5, ram_addr=0x045, bank_valid=1.
- Skip: requests only on banks 1 and 6, rr_ptr=2 -> bank 6 granted first, then bank 1; banks 2–5 never presented.
- Dwell cap, MAX_DWELL=4: bank 2 requested continuously and bank 3 pending -> bank 2 held exactly 4 cycles, then bank 3. With bank 3 not pending, bank 2 is held indefinitely.
- Completion: all chan_done pulsed at different cycles, heads drain -> one image_done pulse, busy falls the same cycle, state IDLE. A start during busy is ignored.
- Wrap: image_base=0x3FE, bank 3 -> ram_addr=0x001.
- Reset mid-RUN with bank_valid=1 -> next cycle all outputs 0; image_done never asserted.
